// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and constants for the RV32I pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ctrl_timer.sv
// Loadable up/down counter with a terminal-count flag.
module ctrl_timer #(
  parameter int W    = 4,
  parameter bit UP   = 1'b0,
  parameter int TERM = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term
);

  localparam logic [W-1:0] TV = W'(TERM);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       count <= '0;
    else if (load)  count <= load_val;
    else if (en)    count <= UP ? count + 1'b1 : count - 1'b1;
  end

  assign term = (count == TV);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: PC / IF-ID / ID-EX hold and flush strobes for jumps,
// load-use stalls and multi-cycle EX ops.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AW          = 32,
  parameter int FLUSH_EXTRA = 1,
  parameter int MC_TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_en_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          load_use_i,
  input  logic          mc_start_i,
  input  logic          mc_done_i,
  output logic          pc_hold_o,
  output logic          pc_jump_en_o,
  output logic [AW-1:0] pc_jump_addr_o,
  output logic          if_id_hold_o,
  output logic          if_id_flush_o,
  output logic          id_ex_hold_o,
  output logic          id_ex_flush_o,
  output logic          mc_err_o,
  output logic [1:0]    state_o
);

  localparam int         TW = $clog2(MC_TIMEOUT);
  localparam logic [3:0] FE = 4'(FLUSH_EXTRA);

  state_t state, nxt;
  logic   flush_load, tmo_load, err_set, flush_term, tmo_term, mc_err;
  logic   ph, pj, ih, ifl, eh, efl;

  ctrl_timer #(.W(4), .UP(1'b0), .TERM(1)) u_flush (
    .clk, .rst, .load(flush_load), .load_val(FE),
    .en(state == ST_FLUSH), .term(flush_term)
  );

  ctrl_timer #(.W(TW), .UP(1'b1), .TERM(MC_TIMEOUT-1)) u_tmo (
    .clk, .rst, .load(tmo_load), .load_val('0),
    .en(state == ST_MC_WAIT), .term(tmo_term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      mc_err <= 1'b0;
    end else begin
      state  <= nxt;
      if (err_set) mc_err <= 1'b1;
    end
  end

  always_comb begin
    nxt = state; flush_load = 1'b0; tmo_load = 1'b0; err_set = 1'b0;
    ph = 1'b0; pj = 1'b0; ih = 1'b0; ifl = 1'b0; eh = 1'b0; efl = 1'b0;
    case (state)
      ST_IDLE, ST_FLUSH: begin
        if (jump_en_i) begin
          pj = 1'b1; ifl = 1'b1; efl = 1'b1;
          if (FLUSH_EXTRA > 0) begin
            nxt = ST_FLUSH; flush_load = 1'b1;
          end else begin
            nxt = ST_IDLE;
          end
        end else if (state == ST_FLUSH) begin
          // ID holds a NOP here, so stall/issue requests are meaningless
          ifl = 1'b1;
          if (flush_term) nxt = ST_IDLE;
        end else if (mc_start_i) begin
          nxt = ST_MC_WAIT; tmo_load = 1'b1;
        end else if (load_use_i) begin
          ph = 1'b1; ih = 1'b1; efl = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        if (mc_done_i) begin
          nxt = ST_IDLE;
        end else if (tmo_term) begin
          nxt = ST_IDLE; err_set = 1'b1;
        end else begin
          ph = 1'b1; ih = 1'b1; eh = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Gate with rst so nothing escapes while reset is asserted; flush beats hold.
  assign pc_hold_o      = rst & ph;
  assign pc_jump_en_o   = rst & pj;
  assign pc_jump_addr_o = (rst & pj) ? jump_addr_i : '0;
  assign if_id_flush_o  = rst & ifl;
  assign if_id_hold_o   = rst & ih & ~ifl;
  assign id_ex_flush_o  = rst & efl;
  assign id_ex_hold_o   = rst & eh & ~efl;
  assign mc_err_o       = mc_err;
  assign state_o        = state;

endmodule
